fifo_ctrl: RTL and testbench

FIFO_CTRL -- requirements
Module: fifo_ctrl

---
 rtl/fifo_pkg.sv | 16 +
 rtl/fifo_ptr.sv | 22 ++
 rtl/fifo_ctrl.sv | 131 +++++++++++++
 tb/tb_fifo_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller: FSM state encoding and the
// pointer-width helper used to size wrap-bit pointers.
package fifo_pkg;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } fifo_state_t;

    // Index bits plus one wrap bit.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: low bits index the storage, MSB toggles on every wrap.
module fifo_ptr #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    localparam logic [PW-1:0] ONE = {{(PW-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ONE;
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller for an external storage array; status flags
// come only from registered pointers, strobes are combinational.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         push_i,
    input  logic                         pop_i,
    output logic                         wr_en_o,
    output logic [$clog2(DEPTH)-1:0]     wr_addr_o,
    output logic                         rd_en_o,
    output logic [$clog2(DEPTH)-1:0]     rd_addr_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         almost_full_o,
    output logic [ptr_width(DEPTH)-1:0]  count_o,
    output logic                         ovf_o,
    output logic                         udf_o,
    output fifo_state_t                  state_o
);

    // Handshake: a push (pop) request is accepted in the cycle it is high and
    // wr_en_o (rd_en_o) is asserted; there is no retry, a refused request is
    // simply dropped and recorded in the sticky error flags.

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(AF_LEVEL);
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count_next;
    logic          push_acc;
    logic          pop_acc;

    fifo_state_t state_q;
    fifo_state_t state_d;

    assign count_o       = wr_ptr - rd_ptr;
    assign empty_o       = (wr_ptr == rd_ptr);
    assign full_o        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign almost_full_o = (count_o >= AF_CNT);

    // Flags are registered state, so a pop into an empty queue is refused even
    // when a push arrives in the same cycle.
    assign pop_acc  = pop_i && !empty_o && !flush && !rst;
    assign push_acc = push_i && !flush && !rst && (!full_o || pop_acc);

    assign wr_en_o   = push_acc;
    assign rd_en_o   = pop_acc;
    assign wr_addr_o = wr_ptr[AW-1:0];
    assign rd_addr_o = rd_ptr[AW-1:0];

    fifo_ptr #(.PW(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (push_acc),
        .ptr (wr_ptr)
    );

    fifo_ptr #(.PW(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .clr (flush),
        .inc (pop_acc),
        .ptr (rd_ptr)
    );

    // A pop on empty alongside an accepted push is not counted as underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            if (push_i && full_o && !pop_acc && !flush) begin
                ovf_o <= 1'b1;
            end
            if (pop_i && empty_o && !flush && !push_acc) begin
                udf_o <= 1'b1;
            end
        end
    end

    assign count_next = count_o + PW'(push_acc) - PW'(pop_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push_acc && !pop_acc) begin
                        state_d = (count_next == FULL_CNT) ? FULL : ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (count_next == FULL_CNT) begin
                        state_d = FULL;
                    end else if (count_next == '0) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop_acc && !push_acc) begin
                        state_d = (count_next == '0) ? EMPTY : ACTIVE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized self-checking bench for fifo_ctrl against an occupancy/queue model.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        push_i;
    logic        pop_i;
    logic        wr_en_o;
    logic [1:0]  wr_addr_o;
    logic        rd_en_o;
    logic [1:0]  rd_addr_o;
    logic        full_o;
    logic        empty_o;
    logic        almost_full_o;
    logic [2:0]  count_o;
    logic        ovf_o;
    logic        udf_o;
    fifo_state_t state_o;

    fifo_ctrl #(.DEPTH(DEPTH), .AF_LEVEL(AF)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .push_i        (push_i),
        .pop_i         (pop_i),
        .wr_en_o       (wr_en_o),
        .wr_addr_o     (wr_addr_o),
        .rd_en_o       (rd_en_o),
        .rd_addr_o     (rd_addr_o),
        .full_o        (full_o),
        .empty_o       (empty_o),
        .almost_full_o (almost_full_o),
        .count_o       (count_o),
        .ovf_o         (ovf_o),
        .udf_o         (udf_o),
        .state_o       (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model: occupancy, push/pop totals, queue of slot addresses
    int         m_cnt;
    int         m_wr_tot;
    int         m_rd_tot;
    bit         m_ovf;
    bit         m_udf;
    logic [1:0] exp_q[$];
    bit         e_push;
    bit         e_pop;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_wr_tot = 0; m_rd_tot = 0;
        m_ovf = 0; m_udf = 0;
        exp_q.delete();
    endtask

    task automatic check_outputs();
        int exp_state;
        e_pop  = pop_i && (m_cnt > 0) && !flush && !rst;
        e_push = push_i && !flush && !rst && ((m_cnt < DEPTH) || e_pop);
        exp_state = (m_cnt == 0) ? int'(EMPTY) : (m_cnt == DEPTH) ? int'(FULL) : int'(ACTIVE);
        check("count",   int'(count_o), m_cnt);
        check("empty",   int'(empty_o), int'(m_cnt == 0));
        check("full",    int'(full_o), int'(m_cnt == DEPTH));
        check("afull",   int'(almost_full_o), int'(m_cnt >= AF));
        check("ovf",     int'(ovf_o), int'(m_ovf));
        check("udf",     int'(udf_o), int'(m_udf));
        check("state",   int'(state_o), exp_state);
        check("wr_en",   int'(wr_en_o), int'(e_push));
        check("rd_en",   int'(rd_en_o), int'(e_pop));
        check("wr_addr", int'(wr_addr_o), m_wr_tot % DEPTH);
        check("rd_addr", int'(rd_addr_o), m_rd_tot % DEPTH);
        if (e_pop && exp_q.size() > 0) begin
            check("pop_slot", int'(rd_addr_o), int'(exp_q.pop_front()));
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else if (flush) begin
            m_cnt = 0; m_wr_tot = 0; m_rd_tot = 0;
            exp_q.delete();
        end else begin
            if (push_i && m_cnt == DEPTH && !e_pop) m_ovf = 1;
            if (pop_i && m_cnt == 0 && !e_push) m_udf = 1;
            if (e_push) begin
                exp_q.push_back(2'(m_wr_tot % DEPTH));
                m_wr_tot++;
                m_cnt++;
            end
            if (e_pop) begin
                m_rd_tot++;
                m_cnt--;
            end
        end
    endtask

    // driver: one clock cycle with the given inputs
    task automatic step(input bit p, input bit q, input bit f, input bit r);
        push_i = p; pop_i = q; flush = f; rst = r;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; push_i = 1'b0; pop_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_count", int'(count_o), 0);
        check("rst_empty", int'(empty_o), 1);
        check("rst_full",  int'(full_o), 0);
        check("rst_errs",  int'({ovf_o, udf_o}), 0);
        @(posedge clk);
        #1;

        // fill, overflow, full push+pop
        repeat (4) step(1, 0, 0, 0);
        check("fill_count", int'(count_o), 4);
        step(1, 0, 0, 0);
        check("ovf_set", int'(ovf_o), 1);
        step(1, 1, 0, 0);
        check("full_pp", int'(full_o), 1);
        // drain, then empty push+pop and empty pop
        repeat (4) step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("empty_pp_cnt", int'(count_o), 1);
        check("empty_pp_udf", int'(udf_o), 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("udf_set", int'(udf_o), 1);
        // wrap with interleaving, then flush with push high
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0);
            step(0, 1, 0, 0);
        end
        repeat (2) step(1, 0, 0, 0);
        step(1, 0, 1, 0);
        check("flush_empty", int'(empty_o), 1);
        check("flush_errs", int'({ovf_o, udf_o}), 3);
        // reset mid-operation
        repeat (3) step(1, 0, 0, 0);
        step(1, 1, 0, 1);
        check("midrst_count", int'(count_o), 0);
        check("midrst_errs", int'({ovf_o, udf_o}), 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
